// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite layer mapper.
// Optional macro SPRITE_MIRROR_EN adds a per-sprite horizontal flip bit.
package sprite_pkg;

    localparam int DEF_NUM_SPRITES = 4;
    localparam int DEF_SHEET_COLS  = 4;
    localparam int DEF_SHEET_ROWS  = 4;
    localparam int DEF_TILE_W      = 32;
    localparam int DEF_TILE_H      = 52;
    localparam int DEF_ADDR_W      = 15;
    localparam int DEF_ROM_LATENCY = 1;

    localparam logic [23:0] KEY_COLOR = 24'hFF0000;
    // All-ones hit index; callers slice it to their index width.
    localparam logic [7:0]  BG_IDX    = 8'hFF;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef struct packed {
        logic       en;
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] sel;
`ifdef SPRITE_MIRROR_EN
        logic       flip;
`endif
    } sprite_attr_t;

endpackage

// File: rtl/sprite_hit_unit.sv
// Combinational hit test and sheet address for one sprite layer.
// With SPRITE_MIRROR_EN defined, a flip input mirrors the tile horizontally.
module sprite_hit_unit
    import sprite_pkg::*;
#(
    parameter int SHEET_COLS = DEF_SHEET_COLS,
    parameter int SHEET_ROWS = DEF_SHEET_ROWS,
    parameter int TILE_W     = DEF_TILE_W,
    parameter int TILE_H     = DEF_TILE_H
) (
    input  logic        en,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic [7:0]  sel,
`ifdef SPRITE_MIRROR_EN
    input  logic        flip,
`endif
    input  logic [9:0]  draw_x,
    input  logic [9:0]  draw_y,
    output logic        hit,
    output logic [19:0] addr
);

    localparam int NUM_TILES = SHEET_COLS * SHEET_ROWS;

    logic [10:0] x_end;
    logic [10:0] y_end;
    logic        in_x;
    logic        in_y;
    logic        sel_ok;
    logic [7:0]  r;
    logic [7:0]  c;
    logic [9:0]  dx_raw;
    logic [9:0]  dx;
    logic [9:0]  dy;
    logic [19:0] row;

    // 11-bit edges keep x+TILE_W from wrapping near the screen edge.
    always_comb begin
        x_end  = {1'b0, x} + 11'(TILE_W);
        y_end  = {1'b0, y} + 11'(TILE_H);
        in_x   = (draw_x >= x) && ({1'b0, draw_x} < x_end);
        in_y   = (draw_y >= y) && ({1'b0, draw_y} < y_end);
        sel_ok = 32'(sel) < NUM_TILES;
        hit    = en && sel_ok && in_x && in_y;
        r      = 8'(32'(sel) / SHEET_COLS);
        c      = 8'(32'(sel) % SHEET_COLS);
        dx_raw = draw_x - x;
        dy     = draw_y - y;
        dx     = dx_raw;
`ifdef SPRITE_MIRROR_EN
        if (flip)
            dx = 10'(TILE_W - 1) - dx_raw;
`endif
        row    = 20'(r) * 20'(TILE_H) + 20'(dy);
        addr   = 20'(SHEET_COLS * TILE_W) * row
               + 20'(c) * 20'(TILE_W) + 20'(dx);
    end

endmodule

// File: rtl/sprite_layer_mapper.sv
// Multi-sprite compositor over the gradient background, fixed priority.
// SPRITE_MIRROR_EN adds the sprite_flip staging input for mirroring.
module sprite_layer_mapper
    import sprite_pkg::*;
#(
    parameter  int NUM_SPRITES = DEF_NUM_SPRITES,
    parameter  int SHEET_COLS  = DEF_SHEET_COLS,
    parameter  int SHEET_ROWS  = DEF_SHEET_ROWS,
    parameter  int TILE_W      = DEF_TILE_W,
    parameter  int TILE_H      = DEF_TILE_H,
    parameter  int ADDR_W      = DEF_ADDR_W,
    parameter  int ROM_LATENCY = DEF_ROM_LATENCY,
    localparam int IDX_W       = $clog2(NUM_SPRITES) + 1
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     frame_start,
    input  logic                     pixel_valid,
    input  logic [9:0]               DrawX,
    input  logic [9:0]               DrawY,
    input  logic [NUM_SPRITES-1:0]   sprite_en,
    input  logic [NUM_SPRITES*10-1:0] sprite_x,
    input  logic [NUM_SPRITES*10-1:0] sprite_y,
    input  logic [NUM_SPRITES*8-1:0] sprite_sel,
`ifdef SPRITE_MIRROR_EN
    input  logic [NUM_SPRITES-1:0]   sprite_flip,
`endif
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [31:0]              rom_data,
    output logic [7:0]               Red,
    output logic [7:0]               Green,
    output logic [7:0]               Blue,
    output logic                     rgb_valid,
    output logic [IDX_W-1:0]         hit_idx
);

    localparam int                 L  = ROM_LATENCY;
    localparam logic [IDX_W-1:0]   BG = BG_IDX[IDX_W-1:0];

    sprite_attr_t staged [NUM_SPRITES];
    sprite_attr_t active [NUM_SPRITES];

    logic [NUM_SPRITES-1:0] hit;
    logic [19:0]            hit_addr [NUM_SPRITES];
    logic                   win;
    logic [IDX_W-1:0]       win_idx;
    logic [19:0]            win_addr;

    logic [L:0]             p_valid;
    logic [L:0]             p_bg;
    logic [IDX_W-1:0]       p_idx [L+1];
    logic [6:0]             p_dx3 [L+1];

    rgb_t                   texel;
    rgb_t                   nxt_rgb;
    logic [IDX_W-1:0]       nxt_idx;
    logic                   unused_rom_hi;

    assign texel         = rom_data[23:0];
    assign unused_rom_hi = ^rom_data[31:24];

    // Gather the flat staging ports into attribute records.
    always_comb begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
            staged[i].en  = sprite_en[i];
            staged[i].x   = sprite_x[i*10 +: 10];
            staged[i].y   = sprite_y[i*10 +: 10];
            staged[i].sel = sprite_sel[i*8 +: 8];
`ifdef SPRITE_MIRROR_EN
            staged[i].flip = sprite_flip[i];
`endif
        end
    end

    // Shadow set: only changes at frame_start, so a frame never tears.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_SPRITES; i++)
                active[i] <= '0;
        end else if (frame_start) begin
            for (int i = 0; i < NUM_SPRITES; i++)
                active[i] <= staged[i];
        end
    end

    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_hit
        sprite_hit_unit #(
            .SHEET_COLS (SHEET_COLS),
            .SHEET_ROWS (SHEET_ROWS),
            .TILE_W     (TILE_W),
            .TILE_H     (TILE_H)
        ) u_hit (
            .en     (active[i].en),
            .x      (active[i].x),
            .y      (active[i].y),
            .sel    (active[i].sel),
`ifdef SPRITE_MIRROR_EN
            .flip   (active[i].flip),
`endif
            .draw_x (DrawX),
            .draw_y (DrawY),
            .hit    (hit[i]),
            .addr   (hit_addr[i])
        );
    end

    // Lowest index wins; scanning downward lets it overwrite the rest.
    always_comb begin
        win      = 1'b0;
        win_idx  = BG;
        win_addr = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                win      = 1'b1;
                win_idx  = IDX_W'(i);
                win_addr = hit_addr[i];
            end
        end
    end

    // Hit-detect register plus delay line matching the ROM read latency.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            rom_addr <= '0;
            p_valid  <= '0;
            p_bg     <= '1;
            for (int i = 0; i <= L; i++) begin
                p_idx[i] <= BG;
                p_dx3[i] <= '0;
            end
        end else begin
            rom_addr   <= ADDR_W'(win_addr);
            p_valid[0] <= pixel_valid;
            p_bg[0]    <= !win;
            p_idx[0]   <= win_idx;
            p_dx3[0]   <= DrawX[9:3];
            for (int i = 1; i <= L; i++) begin
                p_valid[i] <= p_valid[i-1];
                p_bg[i]    <= p_bg[i-1];
                p_idx[i]   <= p_idx[i-1];
                p_dx3[i]   <= p_dx3[i-1];
            end
        end
    end

    // A keyed texel falls through to the background, not a lower sprite.
    always_comb begin
        nxt_rgb = '0;
        nxt_idx = BG;
        if (p_valid[L]) begin
            if (!p_bg[L] && texel != KEY_COLOR) begin
                nxt_rgb = texel;
                nxt_idx = p_idx[L];
            end else begin
                nxt_rgb.r = 8'h3F;
                nxt_rgb.g = 8'h00;
                nxt_rgb.b = 8'h3F - {1'b0, p_dx3[L]};
            end
        end
    end

    // Output register.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            Red       <= '0;
            Green     <= '0;
            Blue      <= '0;
            rgb_valid <= 1'b0;
            hit_idx   <= BG;
        end else begin
            Red       <= nxt_rgb.r;
            Green     <= nxt_rgb.g;
            Blue      <= nxt_rgb.b;
            rgb_valid <= p_valid[L];
            hit_idx   <= nxt_idx;
        end
    end

endmodule
